ecg_frame_encoder_ctrl: RTL and testbench
=========================================

Name: ecg_frame_encoder_ctrl

Overview:
- Sequencing controller for the hybrid ECG compression datapath.
- Accepts raw 16-bit ECG samples over a valid/ready stream and groups them into 8-sample frames.
- Per frame: computes first differences, picks the Golomb-Rice parameter k from the mean absolute difference, then schedules emission of run-length (RLC) and Golomb-Rice (GRC) tokens one at a time over a valid/ready output.
- Carries the zero-run count and the predecessor sample across frames.

Parameters:
- FRAME_LEN, 8, samples per frame (power of two; the mean is sum >> log2(FRAME_LEN)).
- T_LO, 100, mean threshold below which k=3.
- T_HI, 500, mean threshold below which k=4; otherwise k=5.
- RUN_MAX, 63, run count that forces an immediate RUN token.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  sample valid.
- in_ready  out  1  controller can accept a sample.
- in_data  in  16  signed ECG sample.
- flush  in  1  emit the pending run; honoured only in FILL with zero samples buffered.
- tok_valid  out  1  token valid.
- tok_ready  in  1  downstream accepts token.
- tok_data  out  12  token.
- k_out  out  3  k of the most recent frame.
- run_out  out  6  pending zero-run count.
- frame_done  out  1  one-cycle pulse when a frame's encoding completes.
- busy  out  1  high in any state other than FILL.

Behaviour:
- Reset (rst_n=0 at a clk edge, any state, including mid-emit):
  - state=FILL; in_ready=1; tok_valid=0; tok_data=0; k_out=3; run_out=0; frame_done=0; busy=0.
  - Predecessor prev=0; buffer index=0; abs-sum=0.
- FILL:
  - A sample is accepted on in_valid&in_ready.
  - Store d[i] = in_data - prev, as a 16-bit two's-complement wrap.
  - Set prev = in_data and add |d[i]| to a 19-bit sum (|-32768| = 32768).
  - On the FRAME_LEN-th accept, go to KSEL; in_ready=0 from the next cycle.
- KSEL (1 cycle):
  - mean = sum >> 3.
  - k = 3 if mean < T_LO; k = 4 if mean < T_HI; else k = 5.
  - Register k_out; clear sum; i=0; go to SCAN.
- Per sample:
  - q = d / 2^k, truncated toward zero, saturated to 4-bit signed [-8, 7].
  - r = d rem 2^k (sign follows d), computed before saturation, sign-extended to 6 bits.
- SCAN (1 cycle per sample, examines d[i]):
  - q==0:
    - run += 1.
    - If run reaches RUN_MAX, go to EMIT_RUN (then advance i).
    - Otherwise advance i.
  - q!=0:
    - If run != 0, go to EMIT_RUN and then EMIT_GR.
    - Otherwise go to EMIT_GR.
  - After i = FRAME_LEN-1 is fully processed, pulse frame_done for 1 cycle and return to FILL (in_ready=1 the same cycle).
- EMIT_RUN:
  - tok_data = {2'b00, 4'b0000, run}; tok_valid=1.
  - On tok_ready: run=0, continue.
- EMIT_GR:
  - tok_data = {kc, q[3:0], r[5:0]}, with kc = 01/10/11 for k = 3/4/5; tok_valid=1.
  - On tok_ready: advance i.
- Handshake rules:
  - tok_data is stable while tok_valid=1 and tok_ready=0.
  - tok_valid never drops without a transfer.
  - At most one token per cycle.
  - A transfer leaves tok_valid=0 for at least the following cycle.
- Frames yielding no tokens (all q=0, run < RUN_MAX) still pulse frame_done; the run carries over to the next frame.
- flush:
  - FILL with index==0 and run != 0: go to EMIT_RUN, then back to FILL. No frame_done pulse.
  - flush is ignored otherwise, including when run==0.
  - If flush and in_valid coincide in that state, flush wins: the sample is not accepted (in_ready=0 that cycle).
- run_out mirrors the live run register at all times.

Test Plan:
- Ramp: reset, then samples 10, 20, …, 80 with tok_ready=1 -> k_out=3; eight tokens of 0x442; one frame_done; run_out=0.
- All-zero frame: next frame of eight samples of 80 -> no tokens; frame_done; run_out=8. Then 80×7 followed by 120 -> tokens 0x00F, then 0x540.
- Negative and k=5:
  - Prev 120, samples 100, 80, …, -40 (diff -20) -> k=3; eight tokens of 0x7BC.
  - A frame of diffs +600 -> k_out=5; tokens 0xDD8 (q saturated to 7).
- Backpressure: hold tok_ready=0 for 5 cycles during EMIT_GR -> tok_valid=1 and tok_data constant for all 5 cycles; in_ready=0; exactly one transfer when tok_ready rises.
- Run saturation and flush:
  - 63 consecutive zero diffs across frames -> token 0x03F emitted at the 63rd; run_out=0.
  - Then 5 zero diffs and flush at a frame boundary -> token 0x005.
- Reset mid-emit: assert rst_n=0 for one edge while tok_valid=1 -> next cycle tok_valid=0, in_ready=1, run_out=0, k_out=3. The following frame is differenced against prev=0.

Source files
------------

// File: rtl/ecg_frame_encoder_ctrl_if.sv
// Sample-in and token-out valid/ready streams of the ECG frame encoder.
interface ecg_frame_encoder_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        tok_valid;
    logic        tok_ready;
    logic [11:0] tok_data;

    modport master (
        output in_valid, in_data, tok_ready,
        input  in_ready, tok_valid, tok_data
    );

    modport slave (
        input  in_valid, in_data, tok_ready,
        output in_ready, tok_valid, tok_data
    );
endinterface

// File: rtl/ecg_frame_encoder_ctrl.sv
// ECG frame encoder sequencer: frames samples, picks Golomb-Rice k per
// frame and issues RUN / GR tokens one at a time.
module ecg_frame_encoder_ctrl #(
    parameter int FRAME_LEN = 8,
    parameter int T_LO      = 100,
    parameter int T_HI      = 500,
    parameter int RUN_MAX   = 63
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ecg_frame_encoder_ctrl_if.slave bus,
    input  logic                    flush,
    output logic [2:0]              k_out,
    output logic [5:0]              run_out,
    output logic                    frame_done,
    output logic                    busy
);
    localparam int IW = $clog2(FRAME_LEN);
    localparam int SW = 16 + IW;
    localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        FILL, KSEL, SCAN, EMIT_RUN, EMIT_GR
    } state_t;

    state_t        state, state_n;
    logic [15:0]   d [FRAME_LEN];
    logic [15:0]   prev;
    logic [15:0]   diff_in;
    logic [SW-1:0] sum;
    logic [SW-1:0] mean;
    logic [IW-1:0] idx, idx_n;
    logic [5:0]    run, run_n;
    logic [2:0]    k, k_n;
    logic          fl, fl_n;
    logic          done_n;
    logic          adv;
    logic          accept;
    logic [15:0]   dc;
    logic [16:0]   ad, aq;
    logic [5:0]    ar, rq;
    logic [3:0]    q;

    function automatic logic [16:0] mag(input logic [15:0] v);
        return v[15] ? (17'd0 - {v[15], v}) : {1'b0, v};
    endfunction

    assign diff_in = bus.in_data - prev;
    assign accept  = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev <= '0;
            sum  <= '0;
        end else if (accept) begin
            d[idx] <= diff_in;
            prev   <= bus.in_data;
            sum    <= sum + SW'(mag(diff_in));
        end else if (state == KSEL) begin
            sum <= '0;
        end
    end

    // Quotient/remainder are taken on the magnitude, then re-signed,
    // giving truncation toward zero with the remainder following d.
    always_comb begin
        dc = d[idx];
        ad = mag(dc);
        aq = ad >> k;
        ar = ad[5:0] & ((6'd1 << k) - 6'd1);
        if (aq > 17'd7) q = dc[15] ? 4'h8 : 4'h7;
        else            q = dc[15] ? (4'h0 - aq[3:0]) : aq[3:0];
        rq   = dc[15] ? (6'h0 - ar) : ar;
        mean = sum >> IW;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FILL;
            idx        <= '0;
            run        <= '0;
            k          <= 3'd3;
            fl         <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            run        <= run_n;
            k          <= k_n;
            fl         <= fl_n;
            frame_done <= done_n;
        end
    end

    always_comb begin
        state_n       = state;
        idx_n         = idx;
        run_n         = run;
        k_n           = k;
        fl_n          = fl;
        done_n        = 1'b0;
        adv           = 1'b0;
        bus.in_ready  = 1'b0;
        bus.tok_valid = 1'b0;
        bus.tok_data  = '0;
        unique case (state)
            FILL: begin
                if (flush && idx == '0 && run != '0) begin
                    fl_n    = 1'b1;
                    state_n = EMIT_RUN;
                end else begin
                    bus.in_ready = 1'b1;
                    if (bus.in_valid) begin
                        idx_n = idx + IW'(1);
                        if (idx == LAST) state_n = KSEL;
                    end
                end
            end
            KSEL: begin
                if (mean < SW'(T_LO))      k_n = 3'd3;
                else if (mean < SW'(T_HI)) k_n = 3'd4;
                else                       k_n = 3'd5;
                state_n = SCAN;
            end
            SCAN: begin
                if (q == 4'h0) begin
                    run_n = run + 6'd1;
                    if (run_n == 6'(RUN_MAX)) state_n = EMIT_RUN;
                    else                      adv = 1'b1;
                end else begin
                    state_n = (run != '0) ? EMIT_RUN : EMIT_GR;
                end
            end
            EMIT_RUN: begin
                bus.tok_valid = 1'b1;
                bus.tok_data  = {6'b0, run};
                if (bus.tok_ready) begin
                    run_n = '0;
                    if (fl) begin
                        fl_n    = 1'b0;
                        state_n = FILL;
                    end else if (q != 4'h0) begin
                        // rescan the same sample so its GR token follows a gap
                        state_n = SCAN;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            EMIT_GR: begin
                bus.tok_valid = 1'b1;
                bus.tok_data  = {2'(k - 3'd2), q, rq};
                if (bus.tok_ready) adv = 1'b1;
            end
            default: state_n = FILL;
        endcase
        if (adv) begin
            if (idx == LAST) begin
                idx_n   = '0;
                state_n = FILL;
                done_n  = 1'b1;
            end else begin
                idx_n   = idx + IW'(1);
                state_n = SCAN;
            end
        end
    end

    assign busy    = (state != FILL);
    assign k_out   = k;
    assign run_out = run;
endmodule

// File: tb/tb_ecg_frame_encoder_ctrl.sv
// Bench for ecg_frame_encoder_ctrl: directed plan steps plus random
// frames scored against a frame-level token model.
module tb_ecg_frame_encoder_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] k_out;
    logic [5:0] run_out;
    logic       frame_done;
    logic       busy;

    ecg_frame_encoder_ctrl_if bus ();

    ecg_frame_encoder_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .flush      (flush),
        .k_out      (k_out),
        .run_out    (run_out),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          vec = 0;
    int          bad = 0;
    logic [11:0] obs[$];
    int          nd = 0;
    int          obs_base = 0;
    int          nd_base = 0;
    int          expq[$];
    int          exp_nd = 0;
    int          m_prev = 0;
    int          m_run = 0;
    int          m_k = 3;
    bit          rnd = 1'b0;
    logic [15:0] fr[8];
    logic [15:0] cur;
    logic [31:0] first_tok;
    int          dv;

    // Transfers are decided by values stable at the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tok_valid && bus.tok_ready) obs.push_back(bus.tok_data);
            if (frame_done) nd++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        vec++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %0h, expected %0h", tag, o, e);
        end
    endtask

    task automatic tmo(input string tag, input int n, input int lim);
        vec++;
        assert (n < lim) else begin
            bad++;
            $error("FAIL %s: waited %0d cycles, expected under %0d",
                   tag, n, lim);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) bus.tok_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [31:0] tok_at(input int i);
        if (obs_base + i < obs.size()) return 32'(obs[obs_base + i]);
        return 'x;
    endfunction

    // Frame-level reference: differences, k from mean, then tokens.
    task automatic model_frame(input logic [15:0] f[8]);
        int dd[8];
        int s = 0;
        int q, r;
        logic [15:0] w;
        for (int i = 0; i < 8; i++) begin
            w = f[i] - 16'(m_prev);
            dd[i] = int'($signed(w));
            m_prev = int'($signed(f[i]));
            s += (dd[i] < 0) ? -dd[i] : dd[i];
        end
        m_k = (s / 8 < 100) ? 3 : (s / 8 < 500) ? 4 : 5;
        for (int i = 0; i < 8; i++) begin
            q = dd[i] / (1 << m_k);
            r = dd[i] % (1 << m_k);
            if (q > 7) q = 7;
            if (q < -8) q = -8;
            if (q == 0) begin
                m_run++;
                if (m_run == 63) begin
                    expq.push_back(63);
                    m_run = 0;
                end
            end else begin
                if (m_run != 0) begin
                    expq.push_back(m_run);
                    m_run = 0;
                end
                expq.push_back(((m_k - 2) << 10) | ((q & 15) << 6) | (r & 63));
            end
        end
        exp_nd++;
    endtask

    task automatic push(input logic [15:0] s);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = s;
        while (bus.in_ready !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        tmo("push_wait", n, 500);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] f[8]);
        model_frame(f);
        for (int i = 0; i < 8; i++) push(f[i]);
    endtask

    task automatic settle();
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            tick();
            n++;
        end
        tmo("settle", n, 3000);
        tick();
        tick();
    endtask

    task automatic wait_tok();
        int n = 0;
        while (bus.tok_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        tmo("wait_tok", n, 100);
    endtask

    task automatic cmp_frame(input string tag);
        int no;
        no = obs.size() - obs_base;
        chk({tag, "_ntok"}, no, expq.size());
        for (int i = 0; i < expq.size() && i < no; i++)
            chk({tag, "_tok"}, obs[obs_base + i], expq[i]);
        chk({tag, "_fdone"}, nd - nd_base, exp_nd);
        chk({tag, "_run"}, run_out, m_run);
        chk({tag, "_k"}, k_out, m_k);
        obs_base = obs.size();
        nd_base  = nd;
        exp_nd   = 0;
        expq.delete();
    endtask

    task automatic do_flush(input bit with_valid);
        bit idle;
        idle  = (m_run == 0);
        flush = 1'b1;
        if (with_valid) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h1234;
        end
        #1;
        if (with_valid) chk("flush_in_ready", bus.in_ready, 0);
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        if (idle) chk("flush_idle_busy", busy, 0);
        if (!idle) begin
            expq.push_back(m_run);
            m_run = 0;
        end
        settle();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.tok_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_tok_valid", bus.tok_valid, 0);
        chk("rst_tok_data", bus.tok_data, 0);
        chk("rst_k", k_out, 3);
        chk("rst_run", run_out, 0);
        chk("rst_fdone", frame_done, 0);
        chk("rst_busy", busy, 0);

        for (int i = 0; i < 8; i++) fr[i] = 16'(10 * (i + 1));
        send_frame(fr);
        settle();
        chk("ramp_lit", tok_at(0), 32'h442);
        cmp_frame("ramp");

        for (int i = 0; i < 8; i++) fr[i] = 16'd80;
        send_frame(fr);
        settle();
        cmp_frame("zeros");

        for (int i = 0; i < 8; i++) fr[i] = (i == 7) ? 16'd120 : 16'd80;
        send_frame(fr);
        settle();
        chk("runtok_lit", tok_at(0), 32'h00F);
        chk("grtok_lit", tok_at(1), 32'h540);
        cmp_frame("run_then_gr");

        for (int i = 0; i < 8; i++) fr[i] = 16'(100 - 20 * i);
        send_frame(fr);
        settle();
        chk("neg_lit", tok_at(0), 32'h7BC);
        cmp_frame("neg");

        for (int i = 0; i < 8; i++) fr[i] = 16'(-40 + 600 * (i + 1));
        send_frame(fr);
        settle();
        chk("k5_lit", tok_at(0), 32'hDD8);
        cmp_frame("k5");

        bus.tok_ready = 1'b0;
        for (int i = 0; i < 8; i++) fr[i] = 16'(4760 + 600 * (i + 1));
        send_frame(fr);
        wait_tok();
        first_tok = 32'(expq[0]);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", bus.tok_valid, 1);
            chk("bp_data", bus.tok_data, first_tok);
            chk("bp_in_ready", bus.in_ready, 0);
            if (c < 4) tick();
        end
        bus.tok_ready = 1'b1;
        tick();
        chk("bp_one_xfer", obs.size() - obs_base, 1);
        chk("bp_gap", bus.tok_valid, 0);
        settle();
        cmp_frame("bp");

        for (int f = 0; f < 7; f++) begin
            for (int i = 0; i < 8; i++) fr[i] = 16'd9560;
            send_frame(fr);
            settle();
            cmp_frame("sat_fill");
        end
        for (int i = 0; i < 8; i++) fr[i] = (i == 7) ? 16'd9660 : 16'd9560;
        send_frame(fr);
        settle();
        chk("sat_lit", tok_at(0), 32'h03F);
        chk("sat_gr_lit", tok_at(1), 32'h5C4);
        cmp_frame("sat");

        for (int i = 0; i < 8; i++) fr[i] = (i < 3) ? 16'(9710 + 50 * i) : 16'd9810;
        send_frame(fr);
        settle();
        cmp_frame("pre_flush");
        do_flush(1'b1);
        chk("flush_lit", tok_at(0), 32'h005);
        cmp_frame("flush");
        do_flush(1'b0);
        cmp_frame("flush_idle");

        bus.tok_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(16'(9810 + 10 * (i + 1)));
        wait_tok();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_tok_valid", bus.tok_valid, 0);
        chk("mrst_in_ready", bus.in_ready, 1);
        chk("mrst_run", run_out, 0);
        chk("mrst_k", k_out, 3);
        chk("mrst_busy", busy, 0);
        chk("mrst_tok_data", bus.tok_data, 0);
        m_prev = 0;
        m_run  = 0;
        m_k    = 3;
        expq.delete();
        exp_nd   = 0;
        obs_base = obs.size();
        nd_base  = nd;
        bus.tok_ready = 1'b1;
        for (int i = 0; i < 8; i++) fr[i] = 16'd2000;
        send_frame(fr);
        settle();
        chk("mrst_lit", tok_at(0), 32'h9C0);
        cmp_frame("post_rst");

        rnd = 1'b1;
        cur = 16'(m_prev);
        for (int f = 0; f < 16; f++) begin
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 5))
                    0, 1: dv = 0;
                    2: dv = $urandom_range(1, 7);
                    3: dv = $urandom_range(8, 120);
                    4: dv = $urandom_range(100, 900);
                    default: dv = int'($urandom_range(0, 65535));
                endcase
                if ($urandom_range(0, 1) == 1) dv = -dv;
                cur = cur + 16'(dv);
                fr[i] = cur;
            end
            send_frame(fr);
            settle();
            cmp_frame("rnd");
            if (m_run != 0 && $urandom_range(0, 2) == 0) begin
                do_flush(1'($urandom_range(0, 1)));
                cmp_frame("rnd_flush");
            end
        end
        rnd = 1'b0;
        bus.tok_ready = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
